// File: rtl/psram_multiport_ctrl.sv
// Round-robin arbiter driving one async 16-bit PSRAM from NUM_PORTS requesters.
// Access and recovery lengths are fixed cycle counts chosen by parameter.
module psram_multiport_ctrl #(
   parameter int NUM_PORTS       = 2,
   parameter int WAIT_CYCLES     = 3,
   parameter int RECOVERY_CYCLES = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_PORTS-1:0]    req,
   input  logic [NUM_PORTS-1:0]    we,
   input  logic [NUM_PORTS-1:0]    word,
   input  logic [24*NUM_PORTS-1:0] addr,
   input  logic [16*NUM_PORTS-1:0] wdata,
   output logic [16*NUM_PORTS-1:0] rdata,
   output logic [NUM_PORTS-1:0]    ack,
   output logic                    busy,
   output logic                    MemOE,
   output logic                    MemWR,
   output logic                    RamCS,
   output logic                    RamUB,
   output logic                    RamLB,
   output logic                    MemAdv,
   output logic                    MemClk,
   output logic                    RamCRE,
   output logic [22:0]             MemAdr,
   inout  wire  [15:0]             MemDB
);

   localparam int CMAX = (WAIT_CYCLES > RECOVERY_CYCLES) ?
                         WAIT_CYCLES : RECOVERY_CYCLES;
   localparam int CW = $clog2(CMAX);
   localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam logic [CW-1:0] W_LAST = CW'(WAIT_CYCLES - 1);
   localparam logic [CW-1:0] R_LAST = CW'(RECOVERY_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]   rr_q, gidx_q, gsel, cand;
   logic            gnt, load, done;
   logic            we_q, word_q, a0_q;
   logic [15:0]     wd_q, wd_out, rd_val;
   logic [23:0]     sel_addr;
   logic [15:0]     sel_wdata;
   int              j;

   // Cyclic search starting one past the last granted port
   always_comb begin
      gnt  = 1'b0;
      gsel = '0;
      cand = '0;
      j    = 0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         j = int'(rr_q) + k;
         if (j >= NUM_PORTS) j = j - NUM_PORTS;
         cand = PW'(j);
         if (!gnt && req[cand]) begin
            gnt  = 1'b1;
            gsel = cand;
         end
      end
   end

   assign sel_addr  = addr[24*gsel +: 24];
   assign sel_wdata = wdata[16*gsel +: 16];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (gnt) begin
               load    = 1'b1;
               state_d = ACCESS;
               cnt_d   = '0;
            end
         end
         ACCESS: begin
            if (cnt_q == W_LAST) begin
               done    = 1'b1;
               state_d = RECOVER;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RECOVER: begin
            if (cnt_q == R_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign rd_val = word_q ? MemDB :
                   {8'h00, (a0_q ? MemDB[7:0] : MemDB[15:8])};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_q   <= PW'(NUM_PORTS - 1);
         gidx_q <= '0;
         we_q   <= 1'b0;
         word_q <= 1'b0;
         a0_q   <= 1'b0;
         wd_q   <= '0;
         MemAdr <= '0;
         RamCS  <= 1'b1;
         MemOE  <= 1'b1;
         MemWR  <= 1'b1;
         RamUB  <= 1'b1;
         RamLB  <= 1'b1;
         ack    <= '0;
         rdata  <= '0;
      end else begin
         ack <= '0;
         if (load) begin
            gidx_q <= gsel;
            rr_q   <= gsel;
            we_q   <= we[gsel];
            word_q <= word[gsel];
            a0_q   <= sel_addr[0];
            wd_q   <= sel_wdata;
            MemAdr <= sel_addr[23:1];
            RamCS  <= 1'b0;
            MemWR  <= !we[gsel];
            MemOE  <= we[gsel];
            // Byte lane: addr[0]=0 is the upper byte
            RamUB  <= !word[gsel] && sel_addr[0];
            RamLB  <= !word[gsel] && !sel_addr[0];
         end
         if (done) begin
            RamCS <= 1'b1;
            MemOE <= 1'b1;
            MemWR <= 1'b1;
            RamUB <= 1'b1;
            RamLB <= 1'b1;
            ack[gidx_q] <= 1'b1;
            if (!we_q) rdata[16*gidx_q +: 16] <= rd_val;
         end
      end
   end

   assign wd_out = word_q ? wd_q : {wd_q[7:0], wd_q[7:0]};
   assign MemDB  = (state_q == ACCESS && we_q) ? wd_out : 16'hzzzz;

   assign busy   = (state_q != IDLE);
   assign MemAdv = 1'b0;
   assign MemClk = 1'b0;
   assign RamCRE = 1'b0;

endmodule

// File: tb/tb_psram_multiport_ctrl.sv
// Directed bench for psram_multiport_ctrl with a small PSRAM array model.
// A second instance covers a non-default parameter set.
module tb_psram_multiport_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  req = '0, we = '0, word = '0;
   logic [47:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic [1:0]  ack;
   logic        busy, MemOE, MemWR, RamCS, RamUB, RamLB;
   logic        MemAdv, MemClk, RamCRE;
   logic [22:0] MemAdr;
   wire  [15:0] db;

   logic [2:0]  req2 = '0, we2 = '0, word2 = '0;
   logic [71:0] addr2 = '0;
   logic [47:0] wdata2 = '0;
   logic [47:0] rdata2;
   logic [2:0]  ack2;
   logic        busy2, oe2, wr2, cs2, ub2, lb2, adv2, mclk2, cre2;
   logic [22:0] adr2;
   wire  [15:0] db2;

   logic [15:0] mem [0:1023];
   logic [15:0] model_q;
   logic        model_en, probe_en = 1'b0;

   int errors = 0;
   int checks = 0;
   int lat, cs_cnt;
   logic [15:0] s_db;
   logic        s_ub, s_lb, s_oe, s_wr;
   logic [22:0] s_adr;

   always #5 clk = ~clk;

   psram_multiport_ctrl dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .word(word),
      .addr(addr), .wdata(wdata), .rdata(rdata), .ack(ack),
      .busy(busy), .MemOE(MemOE), .MemWR(MemWR), .RamCS(RamCS),
      .RamUB(RamUB), .RamLB(RamLB), .MemAdv(MemAdv),
      .MemClk(MemClk), .RamCRE(RamCRE), .MemAdr(MemAdr),
      .MemDB(db)
   );

   psram_multiport_ctrl #(
      .NUM_PORTS(3), .WAIT_CYCLES(4), .RECOVERY_CYCLES(2)
   ) dut2 (
      .clk(clk), .reset(reset), .req(req2), .we(we2), .word(word2),
      .addr(addr2), .wdata(wdata2), .rdata(rdata2), .ack(ack2),
      .busy(busy2), .MemOE(oe2), .MemWR(wr2), .RamCS(cs2),
      .RamUB(ub2), .RamLB(lb2), .MemAdv(adv2),
      .MemClk(mclk2), .RamCRE(cre2), .MemAdr(adr2),
      .MemDB(db2)
   );

   // PSRAM model: drives the bus on reads, stores enabled lanes on writes
   assign model_en = !RamCS && !MemOE;
   assign model_q  = mem[MemAdr[9:0]];
   assign db = model_en ? model_q : 16'hzzzz;
   assign db = probe_en ? 16'h0000 : 16'hzzzz;

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
         mem[10'h080] <= 16'hA55A;
      end else if (!RamCS && !MemWR) begin
         if (!RamUB) mem[MemAdr[9:0]][15:8] <= db[15:8];
         if (!RamLB) mem[MemAdr[9:0]][7:0]  <= db[7:0];
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 50) begin
         tick();
         n++;
      end
      check(tag, {31'd0, busy}, 32'd0);
   endtask

   task automatic do_acc(input int p, input logic w, input logic wd,
                         input logic [23:0] a, input logic [15:0] d);
      logic got = 1'b0;
      we[p] = w;
      word[p] = wd;
      addr[24*p +: 24] = a;
      wdata[16*p +: 16] = d;
      req[p] = 1'b1;
      lat = 0;
      cs_cnt = 0;
      while (!got && lat < 20) begin
         tick();
         lat++;
         if (lat == 1) begin
            s_ub = RamUB; s_lb = RamLB; s_oe = MemOE;
            s_wr = MemWR; s_adr = MemAdr; s_db = db;
         end
         if (!RamCS) cs_cnt++;
         if (ack[p]) got = 1'b1;
      end
      req[p] = 1'b0;
      check("ack_seen", {31'd0, got}, 32'd1);
   endtask

   int an [4];
   logic [3:0] seq;
   int nack, both;
   int lowc, ack_at, rise, fall2;
   logic prev;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_ctl", {27'd0, RamCS, MemOE, MemWR, RamUB, RamLB},
            32'h1f);
      check("rst_const", {29'd0, MemAdv, MemClk, RamCRE}, 32'd0);
      check("rst_busy_ack", {29'd0, busy, ack}, 32'd0);
      check("rst_adr", {9'd0, MemAdr}, 32'd0);
      reset = 1'b0;
      tick();

      // byte read, lower lane
      do_acc(0, 1'b0, 1'b0, 24'h000101, 16'h0000);
      check("brd_adr", {9'd0, s_adr}, 32'h80);
      check("brd_lanes", {30'd0, s_ub, s_lb}, 32'b10);
      check("brd_oe_wr", {30'd0, s_oe, s_wr}, 32'b01);
      check("brd_lat", lat, 4);
      check("brd_cs_len", cs_cnt, 3);
      check("brd_rdata", {16'd0, rdata[15:0]}, 32'h005A);
      wait_idle("idle_1");

      // byte write, upper lane
      do_acc(0, 1'b1, 1'b0, 24'h000010, 16'h773C);
      check("bwr_db", {16'd0, s_db}, 32'h3C3C);
      check("bwr_lanes", {30'd0, s_ub, s_lb}, 32'b01);
      check("bwr_oe_wr", {30'd0, s_oe, s_wr}, 32'b10);
      check("bwr_adr", {9'd0, s_adr}, 32'h8);
      wait_idle("idle_2");

      // word write then read back on port 1
      do_acc(1, 1'b1, 1'b1, 24'h000200, 16'hBEEF);
      check("wwr_db", {16'd0, s_db}, 32'hBEEF);
      check("wwr_ctl", {29'd0, s_wr, s_ub, s_lb}, 32'd0);
      check("wwr_adr", {9'd0, s_adr}, 32'h100);
      check("wwr_lat", lat, 4);
      wait_idle("idle_3");
      do_acc(1, 1'b0, 1'b1, 24'h000200, 16'h0000);
      check("wrd_rdata1", {16'd0, rdata[31:16]}, 32'hBEEF);
      check("wrd_rdata0_hold", {16'd0, rdata[15:0]}, 32'h005A);
      wait_idle("idle_4");

      // contention: last grant was port 1, so port 0 goes first
      we = 2'b00;
      word = 2'b11;
      addr = {24'h000200, 24'h000100};
      req = 2'b11;
      nack = 0;
      both = 0;
      seq = '0;
      for (int n = 1; n <= 22; n++) begin
         tick();
         if (ack == 2'b11) both++;
         if (ack != 2'b00 && nack < 4) begin
            an[nack] = n;
            seq[nack] = ack[1];
            nack++;
         end
      end
      req = 2'b00;
      check("cont_nack", nack, 4);
      check("cont_order", {28'd0, seq}, 32'b1010);
      check("cont_first", an[0], 4);
      check("cont_gap01", an[1] - an[0], 5);
      check("cont_gap12", an[2] - an[1], 5);
      check("cont_gap23", an[3] - an[2], 5);
      check("cont_both", both, 0);
      wait_idle("idle_5");

      // reset in the middle of a driving write
      do_acc_start();
      tick();
      check("mid_db", {16'd0, db}, 32'h1234);
      tick();
      reset = 1'b1;
      #1;
      check("mid_ctl", {27'd0, RamCS, MemOE, MemWR, RamUB, RamLB},
            32'h1f);
      check("mid_busy_ack", {29'd0, busy, ack}, 32'd0);
      check("mid_rdata", rdata, 32'd0);
      check("mid_adr", {9'd0, MemAdr}, 32'd0);
      probe_en = 1'b1;
      #1;
      check("mid_db_hiz", {16'd0, db}, 32'd0);
      probe_en = 1'b0;
      req = 2'b00;
      tick();
      reset = 1'b0;
      nack = 0;
      for (int n = 0; n < 6; n++) begin
         tick();
         if (ack != 2'b00) nack++;
      end
      check("mid_no_ack", nack, 0);

      // pointer reset: port 0 wins a tie
      we = 2'b00;
      req = 2'b11;
      nack = 0;
      while (ack == 2'b00 && nack < 20) begin
         tick();
         nack++;
      end
      check("rr_reset_win", {30'd0, ack}, 32'b01);
      req = 2'b00;
      wait_idle("idle_6");

      // parameter set 3/4/2, port 2 alone, held
      we2[2] = 1'b1;
      word2[2] = 1'b1;
      addr2[71:48] = 24'h000400;
      wdata2[47:32] = 16'hC0DE;
      req2[2] = 1'b1;
      lowc = 0; ack_at = 0; rise = 0; fall2 = 0; prev = 1'b1;
      for (int n = 1; n <= 12; n++) begin
         tick();
         if (n == 1) check("p2_db", {16'd0, db2}, 32'hC0DE);
         if (!cs2) begin
            if (rise == 0) lowc++;
            else if (fall2 == 0) fall2 = n;
         end else if (!prev && rise == 0) begin
            rise = n;
         end
         if (ack2[2] && ack_at == 0) ack_at = n;
         prev = cs2;
      end
      req2 = '0;
      check("p2_cs_len", lowc, 4);
      check("p2_ack_lat", ack_at, 5);
      check("p2_recover", fall2 - rise, 3);
      nack = 0;
      while (busy2 && nack < 50) begin
         tick();
         nack++;
      end
      check("p2_idle", {31'd0, busy2}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   task automatic do_acc_start();
      we[1] = 1'b1;
      word[1] = 1'b1;
      addr[47:24] = 24'h000300;
      wdata[31:16] = 16'h1234;
      req[1] = 1'b1;
   endtask

endmodule

// File: doc/psram_multiport_ctrl.md
# psram_multiport_ctrl

Parametrised asynchronous PSRAM controller that arbitrates NUM_PORTS independent requesters onto one 16-bit async PSRAM device. It supports byte and 16-bit word reads and writes, and uses round-robin fairness. Wait and recovery timing are set by parameters, so one block serves any clock frequency. It sits between the core's memory clients (CPU fetch, video fetch, DMA) and the board PSRAM pins.

## Interface
- NUM_PORTS, 2: number of requester ports (1..8).
- WAIT_CYCLES, 3: clock cycles chip select is held per access; WAIT_CYCLES × clock period must be at least 70 ns (minimum 2).
- RECOVERY_CYCLES, 1: idle cycles with RamCS high after every access (minimum 1).

Ports (clock and reset first):
- clk  in  1  system clock; everything is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NUM_PORTS  per-port request level; held high until that port's ack.
- we  in  NUM_PORTS  1 = write, 0 = read; sampled at grant.
- word  in  NUM_PORTS  1 = 16-bit access (addr[0] ignored), 0 = byte access.
- addr  in  24*NUM_PORTS  byte address for port i at [24i+23:24i].
- wdata  in  16*NUM_PORTS  write data for port i; a byte write uses [16i+7:16i].
- rdata  out  16*NUM_PORTS  last read result for port i; updated only on that port's read ack.
- ack  out  NUM_PORTS  one-cycle pulse when port i's access completes.
- busy  out  1  high whenever state ≠ IDLE.
- MemOE, MemWR, RamCS, RamUB, RamLB  out  1 each  active-low PSRAM controls.
- MemAdv, MemClk, RamCRE  out  1 each  constant 0 (async mode).
- MemAdr  out  23  word address (addr[23:1]).
- MemDB  inout  16  PSRAM data bus.

## Operation
- States are IDLE, ACCESS and RECOVER. The cycle counter is sized for max(WAIT_CYCLES, RECOVERY_CYCLES).
- **IDLE**, if any req is high:
  - Grant the first requesting port after rr_ptr, searching cyclically.
  - Latch that port's addr, we, word and wdata, plus the grant index.
  - Set rr_ptr to the granted port.
  - Drive the memory controls and go to ACCESS with the counter at 0.
- **Memory controls at grant:**
  - RamCS=0.
  - MemWR=!we and MemOE=we.
  - For a word access, RamUB=RamLB=0.
  - For a byte access, addr[0]=0 selects the upper lane (RamUB=0, RamLB=1); addr[0]=1 selects the lower lane (RamUB=1, RamLB=0).
- **ACCESS:** the counter increments each cycle. On the edge where the counter equals WAIT_CYCLES-1:
  - For a read, capture MemDB into rdata of the granted port:
    - word read: rdata = MemDB;
    - byte read: rdata = {8'h00, selected lane}.
  - Deassert all controls (all high).
  - Pulse ack[granted].
  - Go to RECOVER with the counter at 0.
- **RECOVER:** stay for RECOVERY_CYCLES cycles, then go to IDLE.
- **MemDB drive:**
  - Driven only while in ACCESS with a latched write; Hi-Z at all other times.
  - Word write drives wdata[15:0].
  - Byte write drives {wdata[7:0], wdata[7:0]}.
- **rr_ptr** resets to NUM_PORTS-1, so port 0 wins the first arbitration.
- **Requester rule:**
  - A port may drop req in its ack cycle.
  - If req is still high in IDLE after the ack, that is a new request.
  - Because RECOVERY_CYCLES ≥ 1, a req dropped in the ack cycle is never re-granted.
- **Simultaneous requests:** exactly one grant per IDLE visit. The other requests wait with no loss.
- **Reset**, asynchronous, including mid-access:
  - State goes to IDLE with controls all 1.
  - MemAdr=0, MemDB Hi-Z, ack=0, busy=0, all rdata=0, rr_ptr=NUM_PORTS-1.
  - No ack is issued for an aborted access.

## Timing
- Grant decision is combinational in IDLE. The controls are registered and appear one cycle after the req cycle.
- RamCS is low for exactly WAIT_CYCLES cycles.
- Read data is sampled WAIT_CYCLES cycles after the RamCS falling edge.
- Request-to-ack latency, from the first cycle req is seen in IDLE: WAIT_CYCLES+1 cycles.
- Back-to-back throughput: one access per WAIT_CYCLES+RECOVERY_CYCLES+1 cycles (5 at defaults).
- rdata and ack are valid in the same cycle. rdata holds until the next read ack on that port.
- With all NUM_PORTS ports continuously requesting, each port waits at most NUM_PORTS-1 accesses.

## Test plan
- **Reset:**
  - Stimulus: assert reset mid-ACCESS while a write is driving MemDB.
  - Required: controls go high and MemDB goes Hi-Z immediately; no ack; busy=0; rdata=0.
- **Byte read:**
  - Stimulus: port 0 reads byte at addr 24'h000101; the model returns MemDB=16'hA55A.
  - Required: MemAdr=23'h000080, RamLB=0, RamUB=1; ack[0] appears 4 cycles after req; rdata0=16'h005A.
- **Word write then read:**
  - Stimulus: port 1 writes 16'hBEEF at addr 24'h000200, then reads it back.
  - Required: the write drives MemDB=16'hBEEF with MemWR=0 and both byte enables 0; the read returns rdata1=16'hBEEF.
- **Byte write:**
  - Stimulus: write 8'h3C at addr 24'h000010.
  - Required: MemDB=16'h3C3C, RamUB=0, RamLB=1, MemOE=1.
- **Contention:**
  - Stimulus: req=2'b11 held continuously at defaults.
  - Required: grants alternate 0,1,0,1; acks are spaced 5 cycles apart; no port is starved.
- **Parameters:**
  - Stimulus: NUM_PORTS=3, WAIT_CYCLES=4, RECOVERY_CYCLES=2, with port 2 requesting alone.
  - Required: RamCS low for 4 cycles; ack[2] 5 cycles after req; the next RamCS fall no earlier than 3 cycles after the deassert.
